// File: rtl/dense_stream_mac.sv
// Streaming fully-connected stage: per-input parallel MAC into NUM_OUTPUTS accumulators,
// then a double-buffered serial drain of bias-added, rescaled, saturated results.
module dense_stream_mac #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FRACTION_BITS = 14,
  parameter int unsigned NUM_INPUTS    = 169,
  parameter int unsigned NUM_OUTPUTS   = 10,
  parameter int unsigned ACC_WIDTH     = 40,
  parameter int unsigned RELU          = 0,
  localparam int unsigned AW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1,
  localparam int unsigned IW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic signed [DATA_WIDTH-1:0]        data_in,
  input  logic                                data_in_valid,
  output logic [AW-1:0]                       weight_addr,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   weights,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   bias,
  output logic [DATA_WIDTH-1:0]               dense_out,
  output logic [IW-1:0]                       dense_index,
  output logic                                dense_valid,
  output logic                                frame_done,
  output logic                                overrun
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q  [NUM_OUTPUTS];
  logic signed [ACC_WIDTH-1:0]  acc_d  [NUM_OUTPUTS];
  logic signed [ACC_WIDTH-1:0]  bank_q [NUM_OUTPUTS];
  logic signed [ACC_WIDTH-1:0]  bank_d [NUM_OUTPUTS];
  logic signed [ACC_WIDTH-1:0]  prod_c [NUM_OUTPUTS];
  logic [DATA_WIDTH-1:0]        out_q, out_d;
  logic [IW-1:0]                index_q, index_d;
  logic                         valid_q, valid_d;
  logic                         done_q, done_d;
  logic                         overrun_q, overrun_d;
  logic                         frame_end_c;

  // Bias add, floor rescale, optional ReLU, saturate to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] result_f(input logic signed [ACC_WIDTH-1:0] acc,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    bias_ext = {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
    sum      = acc + (bias_ext <<< FRACTION_BITS);
    shifted  = sum >>> FRACTION_BITS;
    if (RELU != 0 && shifted < 0) shifted = '0;
    if (shifted > SAT_MAX)      result_f = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) result_f = SAT_MIN[DATA_WIDTH-1:0];
    else                        result_f = shifted[DATA_WIDTH-1:0];
  endfunction

  assign frame_end_c = data_in_valid && (addr_q == AW'(NUM_INPUTS - 1));

  // Full-precision products, sign-extended to the accumulator width.
  always_comb begin
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      logic signed [PW-1:0] p;
      p = PW'(data_in) * PW'($signed(weights[j*DATA_WIDTH +: DATA_WIDTH]));
      prod_c[j] = {{(ACC_WIDTH-PW){p[PW-1]}}, p};
    end
  end

  always_comb begin
    acc_d  = acc_q;
    bank_d = bank_q;
    addr_d = addr_q;
    if (data_in_valid) begin
      for (int j = 0; j < NUM_OUTPUTS; j++) acc_d[j] = acc_q[j] + prod_c[j];
      if (frame_end_c) begin
        bank_d = acc_d;
        for (int j = 0; j < NUM_OUTPUTS; j++) acc_d[j] = '0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  // Drain FSM: next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_d     = out_q;
    index_d   = index_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: ;
      DRAIN: begin
        out_d   = result_f(bank_q[idx_q], bias[idx_q*DATA_WIDTH +: DATA_WIDTH]);
        index_d = idx_q;
        valid_d = 1'b1;
        if (idx_q == IW'(NUM_OUTPUTS - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new frame end always restarts the drain on the freshly written bank.
    if (frame_end_c) begin
      if (state_q == DRAIN) overrun_d = 1'b1;
      state_d = DRAIN;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        acc_q[j]  <= '0;
        bank_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      acc_q     <= acc_d;
      bank_q    <= bank_d;
    end
  end

  assign weight_addr = addr_q;
  assign dense_out   = out_q;
  assign dense_index = index_q;
  assign dense_valid = valid_q;
  assign frame_done  = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dense_stream_mac.sv
// Bench for dense_stream_mac: arithmetic model checked every cycle against RELU=0/1 instances,
// plus a NUM_INPUTS=1 instance for the overrun case.
module tb_dense_stream_mac;
  localparam int NI = 4;
  localparam int NO = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic signed [15:0] data_in;
  logic               data_in_valid;
  logic [31:0]        weights, bias;
  logic [1:0]         wa0, wa1;
  logic [15:0]        out0, out1;
  logic               idx0, idx1, v0, v1, fd0, fd1, ov0, ov1;

  logic signed [15:0] data2;
  logic               valid2;
  logic [31:0]        weights2;
  logic               wa2;
  logic [15:0]        out2;
  logic               idx2, v2, fd2, ov2;

  dense_stream_mac #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .RELU(0)) dut0 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .weight_addr(wa0), .weights(weights), .bias(bias), .dense_out(out0),
    .dense_index(idx0), .dense_valid(v0), .frame_done(fd0), .overrun(ov0));

  dense_stream_mac #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .RELU(1)) dut1 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .weight_addr(wa1), .weights(weights), .bias(bias), .dense_out(out1),
    .dense_index(idx1), .dense_valid(v1), .frame_done(fd1), .overrun(ov1));

  dense_stream_mac #(.NUM_INPUTS(1), .NUM_OUTPUTS(NO), .RELU(0)) dut2 (
    .clock(clock), .reset(reset), .data_in(data2), .data_in_valid(valid2),
    .weight_addr(wa2), .weights(weights2), .bias(32'h0), .dense_out(out2),
    .dense_index(idx2), .dense_valid(v2), .frame_done(fd2), .overrun(ov2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: value-level arithmetic of the layer.
  longint      macc [NO];
  int          mcnt, mleft, mpos, eidx;
  logic [15:0] mres0 [NO];
  logic [15:0] mres1 [NO];
  logic [15:0] eout0, eout1;
  logic        ev, efd, eov;
  logic [15:0] mq0 [$];
  logic [15:0] mq1 [$];

  function automatic logic [15:0] fmodel(input longint acc, input longint b, input bit relu);
    longint s, q;
    s = acc + b * 16384;
    q = s / 16384;
    if ((s % 16384) != 0 && s < 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NO; j++) macc[j] = 0;
    mcnt = 0; mleft = 0; mpos = 0; eidx = 0;
    eout0 = '0; eout1 = '0; ev = 0; efd = 0; eov = 0;
  endtask

  task automatic model_step();
    bit was_draining;
    was_draining = (mleft > 0);
    if (mleft > 0) begin
      ev = 1; eidx = mpos; eout0 = mres0[mpos]; eout1 = mres1[mpos];
      efd = (mleft == 1); mpos++; mleft--;
    end else begin
      ev = 0; efd = 0;
    end
    if (data_in_valid) begin
      for (int j = 0; j < NO; j++)
        macc[j] += longint'(data_in) * longint'($signed(weights[j*16 +: 16]));
      mcnt++;
      if (mcnt == NI) begin
        for (int j = 0; j < NO; j++) begin
          mres0[j] = fmodel(macc[j], longint'($signed(bias[j*16 +: 16])), 1'b0);
          mres1[j] = fmodel(macc[j], longint'($signed(bias[j*16 +: 16])), 1'b1);
          mq0.push_back(mres0[j]);
          mq1.push_back(mres1[j]);
          macc[j] = 0;
        end
        if (was_draining) eov = 1;
        mleft = NO; mpos = 0; mcnt = 0;
      end
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      if (reset) model_reset();
      else       model_step();
      #1;
      chk("valid0", v0, ev);   chk("valid1", v1, ev);
      chk("done0", fd0, efd);  chk("done1", fd1, efd);
      chk("ovr0", ov0, eov);   chk("ovr1", ov1, eov);
      chk("waddr0", wa0, mcnt); chk("waddr1", wa1, mcnt);
      if (ev || reset) begin
        chk("out0", out0, eout0); chk("out1", out1, eout1);
        chk("idx0", idx0, eidx);  chk("idx1", idx1, eidx);
      end
    end
  end

  task automatic send(input logic [15:0] d);
    @(negedge clock);
    data_in = d;
    data_in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      data_in_valid = 1'b0;
    end
  endtask

  task automatic lit(input string name, input int k, input logic [15:0] e0, input logic [15:0] e1);
    chk({name, "_relu0"}, mq0[k], e0);
    chk({name, "_relu1"}, mq1[k], e1);
  endtask

  initial begin
    reset = 1'b1; data_in = '0; data_in_valid = 1'b0; weights = '0; bias = '0;
    data2 = '0; valid2 = 1'b0; weights2 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Basic frame: +-0.25 weights on four 1.0 inputs
    weights = 32'hF000_1000; bias = '0;
    mq0.delete(); mq1.delete();
    repeat (4) send(16'h4000);
    idle(4);
    chk("t1_count", mq0.size(), 2);
    lit("t1_n0", 0, 16'h4000, 16'h4000);
    lit("t1_n1", 1, 16'hC000, 16'h0000);

    // Saturation at +-4.0
    weights = 32'hC000_4000;
    mq0.delete(); mq1.delete();
    repeat (4) send(16'h4000);
    idle(4);
    chk("t2_count", mq0.size(), 2);
    lit("t2_n0", 0, 16'h7FFF, 16'h7FFF);
    lit("t2_n1", 1, 16'h8000, 16'h0000);

    // Bias and input gaps
    weights = 32'h1000_1000; bias = 32'hE000_2000;
    mq0.delete(); mq1.delete();
    send(16'h4000); idle(2);
    send(16'h4000); idle(1);
    send(16'h4000); idle(3);
    send(16'h4000); idle(4);
    chk("t3_count", mq0.size(), 2);
    lit("t3_n0", 0, 16'h6000, 16'h6000);
    lit("t3_n1", 1, 16'h2000, 16'h2000);

    // Back-to-back frames
    weights = 32'hF000_1000; bias = '0;
    mq0.delete(); mq1.delete();
    repeat (4) send(16'h4000);
    repeat (4) send(16'h2000);
    idle(5);
    chk("t4_count", mq0.size(), 4);
    lit("t4_f1n0", 0, 16'h4000, 16'h4000);
    lit("t4_f1n1", 1, 16'hC000, 16'h0000);
    lit("t4_f2n0", 2, 16'h2000, 16'h2000);
    lit("t4_f2n1", 3, 16'hE000, 16'h0000);
    chk("t4_no_overrun", ov0, 1'b0);

    // Reset mid-frame discards the partial frame
    mq0.delete(); mq1.delete();
    send(16'h4000); send(16'h4000);
    @(negedge clock); data_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk("t5_rst_waddr", wa0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) send(16'h4000);
    idle(4);
    chk("t5_count", mq0.size(), 2);
    lit("t5_n0", 0, 16'h4000, 16'h4000);
    lit("t5_n1", 1, 16'hC000, 16'h0000);

    // Single-input frames with continuous valid must overrun
    weights2 = 32'h1000_1000;
    @(negedge clock); data2 = 16'h4000; valid2 = 1'b1;
    @(posedge clock); #1;
    chk("t6_e0_ovr", ov2, 1'b0);
    chk("t6_e0_valid", v2, 1'b0);
    @(posedge clock); #1;
    chk("t6_e1_valid", v2, 1'b1);
    chk("t6_e1_out", out2, 16'h1000);
    chk("t6_e1_idx", idx2, 1'b0);
    chk("t6_e1_ovr", ov2, 1'b1);
    @(posedge clock); #1;
    chk("t6_e2_idx", idx2, 1'b0);
    chk("t6_e2_ovr", ov2, 1'b1);
    @(negedge clock); valid2 = 1'b0;
    idle(3);
    chk("t6_sticky", ov2, 1'b1);
    #2 reset = 1'b1;
    #1 chk("t6_rst_ovr", ov2, 1'b0);
    @(negedge clock); reset = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
